// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_bank
// Purpose  : RISC-V style hardware performance counter bank. Holds mcycle,
//            minstret and mhpmcounter3..31, each 64 bits wide, with event
//            selectors (mhpmevent3..31) and an mcountinhibit mask, all reached
//            through a simple registered CSR read/write port.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            retire_valid         - one instruction retired this cycle
//            evt_vec[NEVT]        - event strobes, bit k = event k+1
//            csr_ren/csr_wen      - CSR read / write request
//            csr_addr/csr_wdata   - CSR address / write data
//            csr_rvalid/rdata     - registered read response (one cycle later)
//            csr_wack/csr_err     - write ack / illegal-address pulse
//            ovf_vec[32]          - per-counter wrap pulse
//            perf_value[2048]     - flat image of all 32 counter slots
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_bank #(
    parameter int NEVT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              retire_valid,
    input  logic [NEVT-1:0]   evt_vec,
    input  logic              csr_ren,
    input  logic              csr_wen,
    input  logic [11:0]       csr_addr,
    input  logic [63:0]       csr_wdata,
    output logic              csr_rvalid,
    output logic [63:0]       csr_rdata,
    output logic              csr_err,
    output logic              csr_wack,
    output logic [31:0]       ovf_vec,
    output logic [2047:0]     perf_value
);

    localparam logic [11:0] CNT_BASE = 12'hB00;
    localparam logic [11:0] CSR_INH  = 12'h320;
    localparam logic [11:0] EVT_BASE = 12'h320;

    logic [63:0] cnt_q [32];
    logic [63:0] cnt_d [32];
    logic [4:0]  evt_q [3:31];
    logic [4:0]  evt_d [3:31];
    logic [31:0] inh_q, inh_d;
    logic [31:0] ovf_q, ovf_d;
    logic        rvalid_q, rvalid_d;
    logic        wack_q, wack_d;
    logic        err_q, err_d;
    logic [63:0] rdata_q, rdata_d;

    logic [31:0] cnt_hit;
    logic [31:3] evt_hit;
    logic        inh_hit;
    logic        addr_legal;
    logic [31:0] inc;

    // Address decode. Slot 1 (0xB01) is deliberately left unmapped.
    always_comb begin
        cnt_hit = '0;
        evt_hit = '0;
        for (int i = 0; i < 32; i++) begin
            if (i != 1 && csr_addr == CNT_BASE + 12'(i)) cnt_hit[i] = 1'b1;
        end
        for (int i = 3; i < 32; i++) begin
            if (csr_addr == EVT_BASE + 12'(i)) evt_hit[i] = 1'b1;
        end
        inh_hit    = (csr_addr == CSR_INH);
        addr_legal = (|cnt_hit) || (|evt_hit) || inh_hit;
    end

    // Increment enables. An event selector of 0 or above NEVT never matches
    // because the inner loop only compares against 1..NEVT.
    always_comb begin
        inc    = '0;
        inc[0] = ~inh_q[0];
        inc[2] = retire_valid & ~inh_q[2];
        for (int n = 3; n < 32; n++) begin
            for (int k = 0; k < NEVT; k++) begin
                if (evt_q[n] == 5'(k + 1) && evt_vec[k] && !inh_q[n]) inc[n] = 1'b1;
            end
        end
    end

    // Next-state: a CSR write to a counter wins over its increment and
    // suppresses any wrap pulse. Reads see the pre-update values.
    always_comb begin
        inh_d = inh_q;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = 1'b0;
            if (csr_wen && cnt_hit[i]) begin
                cnt_d[i] = csr_wdata;
            end else if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + 64'd1;
                ovf_d[i] = &cnt_q[i];
            end
        end
        for (int i = 3; i < 32; i++) begin
            evt_d[i] = evt_q[i];
            if (csr_wen && evt_hit[i]) evt_d[i] = csr_wdata[4:0];
        end
        if (csr_wen && inh_hit) inh_d = csr_wdata[31:0] & ~32'h0000_0002;

        rdata_d = '0;
        for (int i = 0; i < 32; i++) begin
            if (cnt_hit[i]) rdata_d = cnt_q[i];
        end
        for (int i = 3; i < 32; i++) begin
            if (evt_hit[i]) rdata_d = {59'd0, evt_q[i]};
        end
        if (inh_hit) rdata_d = {32'd0, inh_q};
        if (!csr_ren) rdata_d = '0;

        rvalid_d = csr_ren;
        wack_d   = csr_wen;
        err_d    = (csr_ren | csr_wen) & ~addr_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
            for (int i = 3; i < 32; i++) evt_q[i] <= '0;
            inh_q    <= '0;
            ovf_q    <= '0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
            for (int i = 3; i < 32; i++) evt_q[i] <= evt_d[i];
            inh_q    <= inh_d;
            ovf_q    <= ovf_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    generate
        for (genvar g = 0; g < 32; g++) begin : g_perf
            assign perf_value[64*g +: 64] = cnt_q[g];
        end
    endgenerate

    assign csr_rvalid = rvalid_q;
    assign csr_rdata  = rdata_q;
    assign csr_wack   = wack_q;
    assign csr_err    = err_q;
    assign ovf_vec    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_counter_bank
// Purpose  : Directed self-checking bench for perf_counter_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_counter_bank;

    localparam int NEVT = 16;

    logic            clk;
    logic            rst_n;
    logic            retire_valid;
    logic [NEVT-1:0] evt_vec;
    logic            csr_ren;
    logic            csr_wen;
    logic [11:0]     csr_addr;
    logic [63:0]     csr_wdata;
    logic            csr_rvalid;
    logic [63:0]     csr_rdata;
    logic            csr_err;
    logic            csr_wack;
    logic [31:0]     ovf_vec;
    logic [2047:0]   perf_value;

    int n_cmp;
    int n_err;
    int cyc;
    logic [63:0] exp_old;
    logic [63:0] hpm_or;

    perf_counter_bank #(.NEVT(NEVT)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .retire_valid (retire_valid),
        .evt_vec      (evt_vec),
        .csr_ren      (csr_ren),
        .csr_wen      (csr_wen),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rvalid   (csr_rvalid),
        .csr_rdata    (csr_rdata),
        .csr_err      (csr_err),
        .csr_wack     (csr_wack),
        .ovf_vec      (ovf_vec),
        .perf_value   (perf_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference count of rising edges since reset release (mcycle model).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [63:0] slot(input int i);
        return perf_value[64*i +: 64];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        csr_ren = 1'b0;
        csr_wen = 1'b0;
    endtask

    task automatic drive_wr(input logic [11:0] a, input logic [63:0] d);
        csr_wen   = 1'b1;
        csr_ren   = 1'b0;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    task automatic drive_rd(input logic [11:0] a);
        csr_ren  = 1'b1;
        csr_wen  = 1'b0;
        csr_addr = a;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        retire_valid = 1'b0;
        evt_vec = '0;
        csr_ren = 1'b0;
        csr_wen = 1'b0;
        csr_addr = '0;
        csr_wdata = '0;

        // Reset state
        @(negedge clk);
        check_eq("rst_perf_zero", {63'd0, |perf_value}, 64'd0);
        check_eq("rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        check_eq("rst_ovf", {32'd0, ovf_vec}, 64'd0);
        rst_n = 1'b1;

        // 10 idle cycles
        repeat (10) @(negedge clk);
        check_eq("idle_mcycle", slot(0), 64'd10);
        check_eq("idle_slot1", slot(1), 64'd0);
        check_eq("idle_minstret", slot(2), 64'd0);
        hpm_or = '0;
        for (int i = 3; i < 32; i++) hpm_or = hpm_or | slot(i);
        check_eq("idle_hpm", hpm_or, 64'd0);

        // Event selector 5 on hpm3, with inhibit for the first 3 of 7 pulses
        drive_wr(12'h323, 64'd5);
        @(negedge clk);
        check_eq("evt_wack", {62'd0, csr_wack, csr_err}, 64'd2);
        drive_wr(12'h320, 64'h8);
        @(negedge clk);
        idle();
        evt_vec = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        drive_wr(12'h320, 64'h0);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        evt_vec = '0;
        check_eq("hpm3_count", slot(3), 64'd4);
        check_eq("hpm4_unselected", slot(4), 64'd0);

        // minstret wrap
        drive_wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        idle();
        retire_valid = 1'b1;
        check_eq("minstret_written", slot(2), 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        retire_valid = 1'b0;
        check_eq("minstret_wrap", slot(2), 64'd0);
        check_eq("ovf_pulse", {32'd0, ovf_vec}, 64'h4);
        @(negedge clk);
        check_eq("ovf_clear", {32'd0, ovf_vec}, 64'd0);

        // Write wins over a same-cycle increment of an all-ones counter
        drive_wr(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        drive_wr(12'hB02, 64'h7);
        retire_valid = 1'b1;
        @(negedge clk);
        idle();
        retire_valid = 1'b0;
        check_eq("wr_priority_val", slot(2), 64'h7);
        check_eq("wr_priority_ovf", {32'd0, ovf_vec}, 64'd0);

        // Simultaneous write and read of mcycle
        exp_old = 64'(cyc);
        drive_wr(12'hB00, 64'h100);
        csr_ren = 1'b1;
        @(negedge clk);
        idle();
        check_eq("rw_flags", {62'd0, csr_rvalid, csr_wack}, 64'd3);
        check_eq("rw_old_rdata", csr_rdata, exp_old);
        check_eq("rw_new_mcycle", slot(0), 64'h100);
        @(negedge clk);
        check_eq("mcycle_resume", slot(0), 64'h101);

        // Illegal address read, then back-to-back legal reads
        drive_rd(12'hB01);
        @(negedge clk);
        check_eq("ill_flags", {62'd0, csr_rvalid, csr_err}, 64'd3);
        check_eq("ill_rdata", csr_rdata, 64'd0);
        drive_rd(12'h323);
        @(negedge clk);
        check_eq("evt_read", csr_rdata, 64'd5);
        check_eq("evt_read_err", {63'd0, csr_err}, 64'd0);
        drive_wr(12'h321, 64'h1234);
        @(negedge clk);
        check_eq("ill_wr_err", {62'd0, csr_wack, csr_err}, 64'd3);
        drive_wr(12'h320, 64'hFFFF_FFFF);
        @(negedge clk);
        drive_rd(12'h320);
        @(negedge clk);
        idle();
        check_eq("inh_read", csr_rdata, 64'hFFFF_FFFD);
        check_eq("inh_frozen_hpm3", slot(3), 64'd4);

        // Count mcycle to 0x55, then reset during an in-flight read
        drive_wr(12'h320, 64'h0);
        @(negedge clk);
        drive_wr(12'hB00, 64'h50);
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        check_eq("mcycle_55", slot(0), 64'h55);
        drive_rd(12'hB00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        check_eq("async_rst_perf", {63'd0, |perf_value}, 64'd0);
        check_eq("async_rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        check_eq("async_rst_rdata", csr_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rvalid", {63'd0, csr_rvalid}, 64'd0);
        check_eq("post_rst_mcycle", slot(0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NEVT, default 16, number of microarchitectural event inputs (1..31).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port retire_valid  input  1  one instruction retired this cycle.
REQ-005 SHALL have port evt_vec  input  NEVT  event strobes, bit k = event k+1 occurred this cycle.
REQ-006 SHALL have port csr_ren  input  1  CSR read request.
REQ-007 SHALL have port csr_wen  input  1  CSR write request.
REQ-008 SHALL have port csr_addr  input  12  CSR address.
REQ-009 SHALL have port csr_wdata  input  64  CSR write data.
REQ-010 SHALL have port csr_rvalid  output  1  read data valid, one-cycle pulse.
REQ-011 SHALL have port csr_rdata  output  64  read data.
REQ-012 SHALL have port csr_err  output  1  illegal-address pulse, same cycle as rvalid or write ack.
REQ-013 SHALL have port csr_wack  output  1  write-accepted pulse.
REQ-014 SHALL have port ovf_vec  output  32  per-counter wrap pulse.
REQ-015 SHALL have port perf_value  output  2048  flat counter image, slot i = bits [64i+63:64i], to the difftest perf-register export stage.

Function
REQ-016 SHALL hold 32 slots: slot 0 mcycle, slot 1 hardwired 0, slot 2 minstret, slots 3..31 mhpmcounter3..31.
REQ-017 SHALL map addresses: 0xB00 mcycle, 0xB02 minstret, 0xB03-0xB1F mhpmcounter, 0x320 mcountinhibit, 0x323-0x33F mhpmevent3..31.
REQ-018 SHALL increment mcycle by 1 each cycle unless mcountinhibit[0]=1.
REQ-019 SHALL increment minstret by 1 when retire_valid=1 and mcountinhibit[2]=0.
REQ-020 SHALL increment mhpmcounterN by 1 when mhpmevent N = k (1..NEVT), evt_vec[k-1]=1, mcountinhibit[N]=0; event value 0 or >NEVT never counts.
REQ-021 SHALL store mhpmevent as 5-bit fields (write uses csr_wdata[4:0], read zero-extends).
REQ-022 SHALL hold mcountinhibit bits 1 read-only 0; bits 0, 2..31 writable from csr_wdata[31:0].
REQ-023 SHALL wrap counters modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF +1 -> 0) and pulse ovf_vec[i] for exactly the cycle after the wrap edge.
REQ-024 SHALL give a CSR write priority over a same-cycle increment of the same counter: counter takes csr_wdata, no increment, no ovf pulse.
REQ-025 SHALL make a written value visible on perf_value the cycle after the write edge; increments resume from the written value the following cycle.
REQ-026 SHALL register reads: csr_ren at edge T -> csr_rvalid=1, csr_rdata = value sampled at T (pre-update) during cycle T+1.
REQ-027 SHALL treat csr_wen at edge T -> csr_wack=1 during cycle T+1.
REQ-028 SHALL treat csr_ren and csr_wen both high as write-then-read-old: rdata returns pre-write value, both rvalid and wack pulse.
REQ-029 SHALL on unmapped address (including 0xB01, 0x321, 0x322) pulse csr_err with rvalid/wack, return rdata 0, change no state.
REQ-030 SHALL accept back-to-back requests every cycle with no stall.
REQ-031 SHALL drive perf_value directly from counter registers (no added latency).

Reset
REQ-032 SHALL on rst_n=0 asynchronously clear all counters, mhpmevent, mcountinhibit, csr_rvalid, csr_wack, csr_err, csr_rdata, ovf_vec to 0.
REQ-033 SHALL abandon an in-flight read when reset asserts mid-request; no rvalid after release.
REQ-034 SHALL start counting mcycle on the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL cover: reset release, 10 idle cycles -> mcycle=10, minstret=0, slot 1=0, all hpm=0.
REQ-036 SHALL cover: write 0x323<=5, pulse evt_vec[4] 7 cycles with mcountinhibit[3]=1 for 3 of them -> mhpmcounter3=4.
REQ-037 SHALL cover: write 0xB02<=0xFFFF_FFFF_FFFF_FFFF, then retire_valid 1 cycle -> minstret=0, ovf_vec[2] one-cycle pulse.
REQ-038 SHALL cover: csr_wen 0xB00<=0x100 with same-cycle csr_ren 0xB00 -> rdata old mcycle, next cycle perf_value slot 0=0x100.
REQ-039 SHALL cover: csr_ren 0xB01 -> rvalid=1, err=1, rdata=0; write 0x320<=0xFFFF_FFFF -> read returns 0xFFFF_FFFD.
REQ-040 SHALL cover: rst_n low mid-count at mcycle=0x55 -> all outputs 0 immediately, no rvalid after release.
